serial_add_arbiter: RTL

- Bit-serial adder engine shared between two requesters. The 1-bit full-adder datapath and the carry flip-flop sit inside this block.
- Each accepted request adds two WIDTH-bit operands plus carry-in, one bit per cycle, LSB first.
- A round-robin arbiter decides which requester owns the engine. A start/grant/done handshake sequences each operation.
- Sits between multi-operand test/ALU sequencers and the shared adder slice.

---
 rtl/serial_add_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: bit-serial WIDTH-bit adder shared by two requesters via round-robin arbitration
// Ports: clk, rst_n (async active-low); req0/a0/b0/cin0 and req1/a1/b1/cin1 request inputs;
// gnt0/gnt1 combinational accept pulses; busy (not idle); sum/cout/done_id result of the last
// completed add; done one-cycle pulse when the result updates.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             done_id
);
  localparam int CW = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             carry, owner, last_id;
  logic             any, win, s, c_nx;
  // With both requesting, the one that did not win last time gets the engine.
  always_comb begin
    any  = req0 | req1;
    win  = (req0 & req1) ? ~last_id : req1;
    s    = a_sh[0] ^ b_sh[0] ^ carry;
    c_nx = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
  end
  // rst_n gates the grants so nothing is accepted while reset is held.
  assign gnt0 = rst_n && state == IDLE && any && !win;
  assign gnt1 = rst_n && state == IDLE && win;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      owner   <= 1'b0;
      last_id <= 1'b1;
      sum     <= '0;
      cout    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          a_sh    <= win ? a1 : a0;
          b_sh    <= win ? b1 : b0;
          carry   <= win ? cin1 : cin0;
          owner   <= win;
          last_id <= win;
          cnt     <= '0;
          state   <= RUN;
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {s, res[WIDTH-1:1]};
          carry <= c_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= DONE;
            sum     <= {s, res[WIDTH-1:1]};
            cout    <= c_nx;
            done_id <= owner;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
